// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer pattern driver: mode codes, FSM states
// and the clock-to-tick divider helpers.
package buzzer_pkg;

    localparam logic [1:0] MODE_CONT         = 2'd0;
    localparam logic [1:0] MODE_BEEP_FOREVER = 2'd1;
    localparam logic [1:0] MODE_BEEP_N       = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Clock cycles per cadence tick.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // The cadence is only exact when the tick rate divides the clock.
    function automatic bit div_exact(input int clk_hz, input int tick_hz);
        return (clk_hz % tick_hz) == 0;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every DIV enabled cycles, phase
// restarted by clr so the first tick lands DIV cycles after clr drops.
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Count 0..DIV-1 while enabled; clr pins the phase to zero.
    always_ff @(posedge CLK) begin
        if (!rst_n || clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/buzzer_pattern.sv
// Buzzer driver: square-wave tone of programmable half-period, gated by an
// on/off cadence (continuous, endless beeps or N beeps).
module buzzer_pattern
    import buzzer_pkg::*;
#(
    parameter int CLK_HZ  = 12_000_000,
    parameter int TICK_HZ = 1000,
    parameter int TONE_W  = 16,
    parameter int DUR_W   = 12,
    parameter int CNT_W   = 8
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [TONE_W-1:0] half_period,
    input  logic [DUR_W-1:0]  on_ticks,
    input  logic [DUR_W-1:0]  off_ticks,
    input  logic [CNT_W-1:0]  repeats,
    output logic              BUZZER,
    output logic              busy,
    output logic              done
);

    localparam int P = calc_div(CLK_HZ, TICK_HZ);

    if (!div_exact(CLK_HZ, TICK_HZ)) begin : g_div_check
        $error("buzzer_pattern: CLK_HZ must be a multiple of TICK_HZ");
    end

    state_t            state;
    logic [1:0]        mode_q;
    logic [TONE_W-1:0] half_q;
    logic [TONE_W-1:0] tone_cnt;
    logic [DUR_W-1:0]  on_q;
    logic [DUR_W-1:0]  off_q;
    logic [DUR_W-1:0]  dur_cnt;
    logic [DUR_W-1:0]  dur_lim;
    logic [CNT_W-1:0]  rep_q;
    logic [CNT_W-1:0]  burst_cnt;
    logic              tick;
    logic              seg_end;
    logic              timed;
    logic              last_burst;
    logic              pre_clr;
    logic              pre_en;

    // Segment bookkeeping: which duration applies now and whether it ends this cycle.
    always_comb begin
        dur_lim    = (state == ST_GAP) ? off_q : on_q;
        seg_end    = tick && (dur_cnt == dur_lim - DUR_W'(1));
        timed      = (mode_q == MODE_BEEP_FOREVER) || (mode_q == MODE_BEEP_N);
        last_burst = (mode_q == MODE_BEEP_N) && (burst_cnt == rep_q - CNT_W'(1));
        // Restart the tick phase on every TONE/GAP entry.
        pre_clr    = (state == ST_IDLE) || seg_end;
        pre_en     = (state != ST_IDLE);
    end

    tick_prescaler #(.DIV(P)) u_prescaler (
        .CLK   (CLK),
        .rst_n (rst_n),
        .clr   (pre_clr),
        .en    (pre_en),
        .tick  (tick)
    );

    // Cadence FSM with tone, duration and burst counters; all outputs registered.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            BUZZER    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mode_q    <= MODE_CONT;
            half_q    <= '0;
            on_q      <= '0;
            off_q     <= '0;
            rep_q     <= '0;
            tone_cnt  <= '0;
            dur_cnt   <= '0;
            burst_cnt <= '0;
        end else if (stop) begin
            state     <= ST_IDLE;
            BUZZER    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tone_cnt  <= '0;
            dur_cnt   <= '0;
            burst_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Reserved mode code behaves as continuous tone.
                        mode_q    <= (mode == 2'd3) ? MODE_CONT : mode;
                        half_q    <= (half_period < TONE_W'(2)) ? TONE_W'(2) : half_period;
                        on_q      <= (on_ticks == '0) ? DUR_W'(1) : on_ticks;
                        off_q     <= off_ticks;
                        rep_q     <= (repeats == '0) ? CNT_W'(1) : repeats;
                        tone_cnt  <= '0;
                        dur_cnt   <= '0;
                        burst_cnt <= '0;
                        BUZZER    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_TONE;
                    end
                end
                ST_TONE: begin
                    if (tone_cnt == half_q - TONE_W'(1)) begin
                        tone_cnt <= '0;
                        BUZZER   <= ~BUZZER;
                    end else begin
                        tone_cnt <= tone_cnt + TONE_W'(1);
                    end
                    if (timed && seg_end) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                        dur_cnt   <= '0;
                        if (last_burst) begin
                            state  <= ST_IDLE;
                            BUZZER <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else if (off_q == '0) begin
                            // Back-to-back burst: restart the tone phase high.
                            BUZZER   <= 1'b1;
                            tone_cnt <= '0;
                        end else begin
                            state  <= ST_GAP;
                            BUZZER <= 1'b0;
                        end
                    end else if (timed && tick) begin
                        dur_cnt <= dur_cnt + DUR_W'(1);
                    end
                end
                ST_GAP: begin
                    BUZZER <= 1'b0;
                    if (seg_end) begin
                        state    <= ST_TONE;
                        BUZZER   <= 1'b1;
                        tone_cnt <= '0;
                        dur_cnt  <= '0;
                    end else if (tick) begin
                        dur_cnt <= dur_cnt + DUR_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buzzer_pattern.sv
module tb_buzzer_pattern;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [15:0] half_period;
  logic [11:0] on_ticks;
  logic [11:0] off_ticks;
  logic [7:0]  repeats;
  logic        BUZZER;
  logic        busy;
  logic        done;

  logic [2:0]  exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          finished = 1'b0;
  string       phase = "init";

  buzzer_pattern #(
    .CLK_HZ (1000),
    .TICK_HZ(100),
    .TONE_W (16),
    .DUR_W  (12),
    .CNT_W  (8)
  ) dut (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .half_period(half_period),
    .on_ticks   (on_ticks),
    .off_ticks  (off_ticks),
    .repeats    (repeats),
    .BUZZER     (BUZZER),
    .busy       (busy),
    .done       (done)
  );

  always #5 CLK = ~CLK;

  task automatic step(input logic bz, input logic by, input logic dn);
    exp_q.push_back({bz, by, dn});
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg(input logic [1:0] md, input logic [15:0] hp,
                     input logic [11:0] on, input logic [11:0] off,
                     input logic [7:0] rep);
    mode        = md;
    half_period = hp;
    on_ticks    = on;
    off_ticks   = off;
    repeats     = rep;
  endtask

  task automatic chk_idle(input string tag);
    n_cmp++;
    if ({BUZZER, busy, done} !== 3'b000 || n_cmp < 2) begin
      n_bad++;
      $display("FAIL %s: reset state got %b required 000 at %0t",
               tag, {BUZZER, busy, done}, $time);
    end
  endtask

  always @(negedge CLK) begin
    logic [2:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({BUZZER, busy, done} !== e) begin
        n_bad++;
        $display("FAIL %s: buzzer/busy/done got %b required %b at %0t",
                 phase, {BUZZER, busy, done}, e, $time);
      end
    end
  end

  initial begin
    #1_000_000;
    if (!finished) begin
      n_bad++;
      $display("FAIL timeout: stimulus did not finish, stuck in phase %s at %0t",
               phase, $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b1; stop = 1'b0;
    cfg(2'd0, 16'd3, 12'd1, 12'd1, 8'd1);

    phase = "reset_hold";
    repeat (5) step(1'b0, 1'b0, 1'b0);
    chk_idle("reset_hold");
    rst_n = 1'b1; start = 1'b0;
    phase = "idle_after_reset";
    repeat (5) step(1'b0, 1'b0, 1'b0);
    chk_idle("idle_after_reset");

    phase = "cont";
    cfg(2'd0, 16'd3, 12'd0, 12'd0, 8'd0); start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step((i % 6) < 3, 1'b1, 1'b0);
      start = 1'b0; half_period = 16'd7;
    end
    phase = "cont_stop"; stop = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    stop = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    phase = "beep_n";
    cfg(2'd2, 16'd2, 12'd2, 12'd1, 8'd3); start = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 20; i++) begin
        step((i % 4) < 2, 1'b1, 1'b0);
        start = 1'b0; cfg(2'd0, 16'd5, 12'd7, 12'd9, 8'd1);
      end
      if (b < 2)
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
    end
    phase = "beep_n_done";
    step(1'b0, 1'b0, 1'b1);

    phase = "clamp";
    cfg(2'd2, 16'd0, 12'd0, 12'd5, 8'd0); start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step((i % 4) < 2, 1'b1, 1'b0);
      start = 1'b0;
    end
    phase = "clamp_done";
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    phase = "mode3";
    cfg(2'd3, 16'd2, 12'd1, 12'd0, 8'd1); start = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step((i % 4) < 2, 1'b1, 1'b0);
      start = 1'b0;
    end
    stop = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    stop = 1'b0;

    phase = "forever";
    cfg(2'd1, 16'd3, 12'd1, 12'd0, 8'd1); start = 1'b1;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 10; i++) begin
        step((i % 6) < 3, 1'b1, 1'b0);
        start = 1'b0;
      end
    phase = "forever_stop"; stop = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    stop = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    phase = "start_stop";
    cfg(2'd0, 16'd3, 12'd1, 12'd1, 8'd1); start = 1'b1; stop = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    start = 1'b0; stop = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    phase = "gap_start";
    cfg(2'd2, 16'd2, 12'd1, 12'd2, 8'd2); start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step((i % 4) < 2, 1'b1, 1'b0);
      start = 1'b0;
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        start = 1'b1; cfg(2'd0, 16'd3, 12'd4, 12'd0, 8'd9);
      end
      step(1'b0, 1'b1, 1'b0);
      start = 1'b0;
    end
    for (int i = 0; i < 10; i++) step((i % 4) < 2, 1'b1, 1'b0);
    phase = "gap_start_done";
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    phase = "rep255";
    cfg(2'd2, 16'd2, 12'd1, 12'd0, 8'd255); start = 1'b1;
    for (int b = 0; b < 255; b++)
      for (int i = 0; i < 10; i++) begin
        step((i % 4) < 2, 1'b1, 1'b0);
        start = 1'b0;
      end
    phase = "rep255_done";
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    phase = "reset_mid";
    cfg(2'd0, 16'd3, 12'd1, 12'd1, 8'd1); start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step((i % 6) < 3, 1'b1, 1'b0);
      start = 1'b0;
    end
    rst_n = 1'b0; start = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk_idle("reset_mid");
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; start = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    @(negedge CLK);
    #1;
    finished = 1'b1;
    if (exp_q.size() != 0 || n_bad != 0) begin
      $display("FAIL end: %0d expectations unconsumed, %0d mismatches",
               exp_q.size(), n_bad);
      if (n_bad == 0) n_bad++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
